// File: rtl/sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_rr_arbiter
// Function : Round-robin arbiter sharing one SRAM port between NumReq
//            requesters, with in-order, Latency-aligned response routing.
// Revision : 1.0 - initial release
// ============================================================================

module sram_rr_arbiter #(
    parameter int NumReq    = 4,
    parameter int AddrWidth = 10,
    parameter int DataWidth = 64,
    parameter int BeWidth   = 8,
    parameter int Latency   = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,

    input  logic [NumReq-1:0]                   req_valid_i,
    output logic [NumReq-1:0]                   req_ready_o,
    input  logic [NumReq-1:0]                   req_we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_i,
    input  logic [NumReq-1:0][BeWidth-1:0]      req_be_i,

    output logic [NumReq-1:0]                   rsp_valid_o,
    output logic [DataWidth-1:0]                rsp_rdata_o,

    output logic                                sram_req_o,
    output logic                                sram_we_o,
    output logic [AddrWidth-1:0]                sram_addr_o,
    output logic [DataWidth-1:0]                sram_wdata_o,
    output logic [BeWidth-1:0]                  sram_be_o,
    input  logic [DataWidth-1:0]                sram_rdata_i
);

    localparam int                 c_ptr_w   = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [c_ptr_w:0]   c_num_req = (c_ptr_w + 1)'(NumReq);
    localparam logic [c_ptr_w-1:0] c_last    = c_ptr_w'(NumReq - 1);

    logic [c_ptr_w-1:0] rr_ptr_q, rr_ptr_d;
    logic [c_ptr_w-1:0] win_idx;
    logic               win_found;
    logic [NumReq-1:0]  grant;

    // Response pipeline: valid, write flag and one-hot originator per stage.
    logic [Latency-1:0]             pv_q, pv_d;
    logic [Latency-1:0]             pw_q, pw_d;
    logic [Latency-1:0][NumReq-1:0] pid_q, pid_d;

    // First valid requester at or above rr_ptr, wrapping modulo NumReq.
    always_comb begin : arb
        logic [c_ptr_w:0] cand;
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        grant     = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = {1'b0, rr_ptr_q} + (c_ptr_w + 1)'(k);
            if (cand >= c_num_req) begin
                cand = cand - c_num_req;
            end
            if (!win_found && req_valid_i[cand[c_ptr_w-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[c_ptr_w-1:0];
            end
        end
        grant[win_idx] = win_found;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (win_found) begin
            rr_ptr_d = (win_idx == c_last) ? '0 : win_idx + 1'b1;
        end
    end

    assign req_ready_o  = grant;
    assign sram_req_o   = win_found;
    assign sram_we_o    = win_found & req_we_i[win_idx];
    assign sram_addr_o  = req_addr_i[win_idx];
    assign sram_wdata_o = req_wdata_i[win_idx];
    assign sram_be_o    = sram_we_o ? req_be_i[win_idx] : '0;

    always_comb begin
        pv_d     = '0;
        pw_d     = '0;
        pid_d    = '0;
        pv_d[0]  = win_found;
        pw_d[0]  = sram_we_o;
        pid_d[0] = grant;
        for (int s = 1; s < Latency; s++) begin
            pv_d[s]  = pv_q[s-1];
            pw_d[s]  = pw_q[s-1];
            pid_d[s] = pid_q[s-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            pv_q     <= '0;
            pw_q     <= '0;
            pid_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            pv_q     <= pv_d;
            pw_q     <= pw_d;
            pid_q    <= pid_d;
        end
    end

    // Write acks carry no data, so the shared bus is zeroed for them.
    assign rsp_valid_o = pv_q[Latency-1] ? pid_q[Latency-1] : '0;
    assign rsp_rdata_o = (pv_q[Latency-1] && !pw_q[Latency-1]) ? sram_rdata_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_rr_arbiter
// Function : Directed-vector bench for sram_rr_arbiter at Latency 1, 2 and 3.
// Revision : 1.0 - initial release
// ============================================================================

module tb_sram_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [3:0]           valid, we;
    logic [3:0][9:0]      addr;
    logic [3:0][63:0]     wdata;
    logic [3:0][7:0]      be;

    logic [3:0]  ready1, ready2, ready3;
    logic [3:0]  rsp1, rsp2, rsp3;
    logic [63:0] rdo1, rdo2, rdo3;
    logic        sreq1, sreq2, sreq3, swe1, swe2, swe3;
    logic [9:0]  saddr1, saddr2, saddr3;
    logic [63:0] swd1, swd2, swd3;
    logic [7:0]  sbe1, sbe2, sbe3;
    logic [63:0] rd_pipe [0:2];

    sram_rr_arbiter #(.NumReq(4), .AddrWidth(10), .DataWidth(64), .BeWidth(8), .Latency(1)) u_l1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(valid), .req_ready_o(ready1), .req_we_i(we), .req_addr_i(addr),
        .req_wdata_i(wdata), .req_be_i(be), .rsp_valid_o(rsp1), .rsp_rdata_o(rdo1),
        .sram_req_o(sreq1), .sram_we_o(swe1), .sram_addr_o(saddr1), .sram_wdata_o(swd1),
        .sram_be_o(sbe1), .sram_rdata_i(rd_pipe[0]));

    sram_rr_arbiter #(.NumReq(4), .AddrWidth(10), .DataWidth(64), .BeWidth(8), .Latency(2)) u_l2 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(valid), .req_ready_o(ready2), .req_we_i(we), .req_addr_i(addr),
        .req_wdata_i(wdata), .req_be_i(be), .rsp_valid_o(rsp2), .rsp_rdata_o(rdo2),
        .sram_req_o(sreq2), .sram_we_o(swe2), .sram_addr_o(saddr2), .sram_wdata_o(swd2),
        .sram_be_o(sbe2), .sram_rdata_i(rd_pipe[1]));

    sram_rr_arbiter #(.NumReq(4), .AddrWidth(10), .DataWidth(64), .BeWidth(8), .Latency(3)) u_l3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(valid), .req_ready_o(ready3), .req_we_i(we), .req_addr_i(addr),
        .req_wdata_i(wdata), .req_be_i(be), .rsp_valid_o(rsp3), .rsp_rdata_o(rdo3),
        .sram_req_o(sreq3), .sram_we_o(swe3), .sram_addr_o(saddr3), .sram_wdata_o(swd3),
        .sram_be_o(sbe3), .sram_rdata_i(rd_pipe[2]));

    // SRAM model: unwritten words read as 0x1000 + address.
    logic [63:0] mem     [0:1023];
    logic        written [0:1023];

    function automatic logic [63:0] base_word(input logic [9:0] a, input logic w, input logic [63:0] m);
        return w ? m : (64'h1000 + {54'd0, a});
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) written[i] <= 1'b0;
        end else if (sreq1 && swe1) begin
            mem[saddr1]     <= merge(base_word(saddr1, written[saddr1], mem[saddr1]), swd1, sbe1);
            written[saddr1] <= 1'b1;
        end
        rd_pipe[0] <= (sreq1 && !swe1) ? base_word(saddr1, written[saddr1], mem[saddr1])
                                       : 64'hBADB_ADBA_DBAD_BAD0;
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [3:0]  ready;
        logic [3:0]  rsp;
        logic [63:0] rdata;
        logic [7:0]  be;
    } vec_t;

    vec_t vecs [19];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        valid = '0;
        we    = '0;
        addr[0] = 10'h000; addr[1] = 10'h001; addr[2] = 10'h005; addr[3] = 10'h003;
        wdata[0] = 64'hFF00; wdata[1] = 64'h1111; wdata[2] = 64'hDEAD; wdata[3] = 64'h3333;
        be[0] = 8'h03; be[1] = 8'h0F; be[2] = 8'hFF; be[3] = 8'hF0;

        // Latency-1 instance: {valid, we, ready, rsp, rdata, sram_be}
        vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000, 64'h0,    8'h00};
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0001, 64'h1000, 8'h00};
        vecs[2]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0010, 64'h1001, 8'h00};
        vecs[3]  = '{4'b1111, 4'b0000, 4'b1000, 4'b0100, 64'h1005, 8'h00};
        vecs[4]  = '{4'b1111, 4'b0000, 4'b0001, 4'b1000, 64'h1003, 8'h00};
        vecs[5]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0001, 64'h1000, 8'h00};
        vecs[6]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0010, 64'h1001, 8'h00};
        vecs[7]  = '{4'b1111, 4'b0000, 4'b1000, 4'b0100, 64'h1005, 8'h00};
        vecs[8]  = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 64'h1003, 8'hFF};
        vecs[9]  = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 64'h0,    8'h00};
        vecs[10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 64'hDEAD, 8'h00};
        vecs[11] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 64'h0,    8'h00};
        vecs[12] = '{4'b1010, 4'b0000, 4'b1000, 4'b0010, 64'h1001, 8'h00};
        vecs[13] = '{4'b1010, 4'b0000, 4'b0010, 4'b1000, 64'h1003, 8'h00};
        vecs[14] = '{4'b1010, 4'b0000, 4'b1000, 4'b0010, 64'h1001, 8'h00};
        vecs[15] = '{4'b0001, 4'b0001, 4'b0001, 4'b1000, 64'h1003, 8'h03};
        vecs[16] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 64'h0,    8'h00};
        vecs[17] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 64'h0,    8'h00};
        vecs[18] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 64'hFF00, 8'h00};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", ready1, 64'h0);
        chk("reset_rsp",   rsp1,   64'h0);
        chk("reset_rdata", rdo1,   64'h0);
        chk("reset_sreq",  sreq1,  64'h0);
        chk("reset_sbe",   sbe1,   64'h0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            valid = vecs[i].valid;
            we    = vecs[i].we;
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), ready1, vecs[i].ready);
            chk($sformatf("v%0d_rsp", i),   rsp1,   vecs[i].rsp);
            chk($sformatf("v%0d_rdata", i), rdo1,   vecs[i].rdata);
            chk($sformatf("v%0d_sbe", i),   sbe1,   vecs[i].be);
            chk($sformatf("v%0d_sreq", i),  sreq1,  {63'd0, |vecs[i].valid});
            step();
        end

        // Latency 3: back-to-back reads by 0 then 1.
        valid = '0;
        we    = '0;
        repeat (4) step();
        valid = 4'b0001;
        @(negedge clk);
        chk("l3_c0_ready", ready3, 64'h1);
        step();
        valid = 4'b0010;
        @(negedge clk);
        chk("l3_c1_ready", ready3, 64'h2);
        chk("l3_c1_rsp",   rsp3,   64'h0);
        step();
        valid = '0;
        @(negedge clk);
        chk("l3_c2_rsp", rsp3, 64'h0);
        step();
        @(negedge clk);
        chk("l3_c3_rsp",   rsp3, 64'h1);
        chk("l3_c3_rdata", rdo3, 64'hFF00);
        step();
        @(negedge clk);
        chk("l3_c4_rsp",   rsp3, 64'h2);
        chk("l3_c4_rdata", rdo3, 64'h1001);
        step();
        @(negedge clk);
        chk("l3_c5_rsp", rsp3, 64'h0);
        step();

        // Latency 2: reset one cycle after a grant drops the response.
        valid = 4'b0100;
        @(negedge clk);
        chk("l2_grant", ready2, 64'h4);
        step();
        valid = '0;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("l2_rst%0d_rsp", k),   rsp2, 64'h0);
            chk($sformatf("l2_rst%0d_rdata", k), rdo2, 64'h0);
            step();
        end
        rst_n = 1'b1;
        valid = 4'b1111;
        @(negedge clk);
        chk("l2_post_reset_ready", ready2, 64'h1);
        chk("l1_post_reset_ready", ready1, 64'h1);
        step();
        valid = '0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
